// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the multicycle RV32I control unit
// Contents: FSM state enum, opcode/funct constants, ALU op codes, mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        RESET    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        WB_ALU   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_LOAD  = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] ALU_IDLE = 3'b000;
    localparam logic [2:0] ALU_SUM  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_REG    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // States that talk to memory and therefore stretch by the wait count.
    function automatic logic is_mem_access(input state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - memory wait-state counter with load, saturating decrement and zero flag
// Ports: clk_i clock; rst_ni async active-low reset; load_i reload with LOAD_VAL;
//        zero_o counter is zero (access completes this cycle).
module mem_wait_counter #(
    parameter logic [3:0] LOAD_VAL = 4'd0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control FSM (add, sub, addi, lw, sw, beq)
// Ports: clk, rst (async active-low); instr, alu_zero inputs;
//        datapath enables (pc_write, ir_write, mem_read, mem_write, reg_write, load_a/b/alu_out),
//        mux selects (pc_src, i_or_d, mem_to_reg, alu_src_a/b), alu_op, sticky trap, state_out.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int ALUOP_W  = 3,
    parameter int STATE_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               alu_zero,
    output logic               pc_write,
    output logic               pc_src,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               load_a,
    output logic               load_b,
    output logic               load_alu_out,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               trap,
    output logic [STATE_W-1:0] state_out
);

    state_e state_q, state_d;
    // Load vs store is resolved in DECODE so MEM_ADDR does not look at instr again.
    logic   is_store_q, is_store_d;
    logic   cnt_load, cnt_zero;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    // Reload the wait counter on every entry into an access state; it then
    // counts down and the access completes in the cycle it reads zero.
    assign cnt_load = is_mem_access(state_d) && (state_d != state_q);

    mem_wait_counter #(
        .LOAD_VAL(4'(MEM_WAIT))
    ) u_wait (
        .clk_i (clk),
        .rst_ni(rst),
        .load_i(cnt_load),
        .zero_o(cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RESET;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        load_a       = 1'b0;
        load_b       = 1'b0;
        load_alu_out = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_REG;
        alu_op       = ALUOP_W'(ALU_IDLE);
        trap         = 1'b0;

        case (state_q)
            RESET: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_read = 1'b1;
                if (cnt_zero) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    alu_op    = ALUOP_W'(ALU_SUM);
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                load_a       = 1'b1;
                load_b       = 1'b1;
                load_alu_out = 1'b1;
                alu_src_a    = SRC_A_OLD_PC;
                alu_src_b    = SRC_B_IMM;
                alu_op       = ALUOP_W'(ALU_SUM);
                if (opcode == OP_RTYPE && funct3 == F3_ADD &&
                    (funct7 == F7_ADD || funct7 == F7_SUB)) begin
                    state_d = EXEC_R;
                end else if (opcode == OP_ITYPE && funct3 == F3_ADD) begin
                    state_d = EXEC_I;
                end else if (opcode == OP_LOAD && funct3 == F3_WORD) begin
                    state_d    = MEM_ADDR;
                    is_store_d = 1'b0;
                end else if (opcode == OP_STORE && funct3 == F3_WORD) begin
                    state_d    = MEM_ADDR;
                    is_store_d = 1'b1;
                end else if (opcode == OP_BRANCH && funct3 == F3_BEQ) begin
                    state_d = BRANCH;
                end else begin
                    state_d = TRAP;
                end
            end
            EXEC_R: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = SRC_B_REG;
                alu_op       = funct7[5] ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_SUM);
                load_alu_out = 1'b1;
                state_d      = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = SRC_B_IMM;
                alu_op       = ALUOP_W'(ALU_SUM);
                load_alu_out = 1'b1;
                state_d      = WB_ALU;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = SRC_B_IMM;
                alu_op       = ALUOP_W'(ALU_SUM);
                load_alu_out = 1'b1;
                state_d      = is_store_q ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (cnt_zero) begin
                    state_d = WB_LOAD;
                end
            end
            WB_LOAD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (cnt_zero) begin
                    state_d = FETCH;
                end
            end
            BRANCH: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                alu_op    = ALUOP_W'(ALU_SUB);
                pc_src    = 1'b1;
                pc_write  = alu_zero;
                state_d   = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = TRAP;
            end
        endcase
    end

    assign state_out = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       mem_to_reg;
        logic       load_a;
        logic       load_b;
        logic       load_alu_out;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic       trap;
    } ctl_t;

    typedef struct {
        ctl_t        c;
        logic [31:0] instr;
        logic        zero;
    } step_t;

    localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_ILL = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_a [4];
    logic        zero_a  [4];
    ctl_t        outs    [4];
    logic [3:0]  st_a    [4];

    int checks   = 0;
    int failures = 0;
    step_t exp_q[$];

    always #5 clk = ~clk;

    // One DUT per wait-state setting; instance g has MEM_WAIT = g.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        ctl_t o;
        multicycle_control_unit #(.MEM_WAIT(g), .ALUOP_W(3), .STATE_W(4)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .instr       (instr_a[g]),
            .alu_zero    (zero_a[g]),
            .pc_write    (o.pc_write),
            .pc_src      (o.pc_src),
            .ir_write    (o.ir_write),
            .mem_read    (o.mem_read),
            .mem_write   (o.mem_write),
            .i_or_d      (o.i_or_d),
            .reg_write   (o.reg_write),
            .mem_to_reg  (o.mem_to_reg),
            .load_a      (o.load_a),
            .load_b      (o.load_b),
            .load_alu_out(o.load_alu_out),
            .alu_src_a   (o.src_a),
            .alu_src_b   (o.src_b),
            .alu_op      (o.alu_op),
            .trap        (o.trap),
            .state_out   (st_a[g])
        );
        assign outs[g] = o;
    end

    // ---------------- reference model: expected per-cycle control words ----------------
    task automatic push(input ctl_t c, input logic [31:0] ins, input logic z);
        step_t s;
        s.c = c; s.instr = ins; s.zero = z;
        exp_q.push_back(s);
    endtask

    // Cycles where the FSM must not look at instr/alu_zero get random junk.
    task automatic push_junk(input ctl_t c);
        push(c, $urandom, 1'($urandom));
    endtask

    task automatic push_reset_cycle();
        push_junk('0);
    endtask

    task automatic model_instr(input int kind, input int w, input logic [31:0] ins, input logic z);
        ctl_t c;
        for (int i = 0; i < w; i++) begin
            c = '0; c.mem_read = 1; push_junk(c);
        end
        c = '0; c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.src_b = 2'b01; c.alu_op = 3'b001;
        push_junk(c);
        c = '0; c.load_a = 1; c.load_b = 1; c.load_alu_out = 1; c.src_a = 2'b10; c.src_b = 2'b10;
        c.alu_op = 3'b001;
        push(c, ins, 1'($urandom));
        case (kind)
            K_ADD, K_SUB, K_ADDI: begin
                c = '0; c.src_a = 2'b01; c.load_alu_out = 1;
                c.src_b  = (kind == K_ADDI) ? 2'b10 : 2'b00;
                c.alu_op = (kind == K_SUB) ? 3'b010 : 3'b001;
                push(c, ins, 1'($urandom));
                c = '0; c.reg_write = 1; push_junk(c);
            end
            K_LW, K_SW: begin
                c = '0; c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 3'b001; c.load_alu_out = 1;
                push_junk(c);
                for (int i = 0; i <= w; i++) begin
                    c = '0; c.i_or_d = 1;
                    if (kind == K_LW) c.mem_read = 1; else c.mem_write = 1;
                    push_junk(c);
                end
                if (kind == K_LW) begin
                    c = '0; c.reg_write = 1; c.mem_to_reg = 1; push_junk(c);
                end
            end
            K_BEQ: begin
                c = '0; c.src_a = 2'b01; c.src_b = 2'b00; c.alu_op = 3'b010; c.pc_src = 1;
                c.pc_write = z;
                push($urandom, 32'h0, 1'b0);
                exp_q[exp_q.size()-1].c     = c;
                exp_q[exp_q.size()-1].instr = $urandom;
                exp_q[exp_q.size()-1].zero  = z;
            end
            default: begin
                c = '0; c.trap = 1;
                repeat (20) push_junk(c);
            end
        endcase
    endtask

    function automatic logic [31:0] rand_instr(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            K_ADD:  begin r[6:0] = 7'b0110011; r[14:12] = 3'b000; r[31:25] = 7'b0000000; end
            K_SUB:  begin r[6:0] = 7'b0110011; r[14:12] = 3'b000; r[31:25] = 7'b0100000; end
            K_ADDI: begin r[6:0] = 7'b0010011; r[14:12] = 3'b000; end
            K_LW:   begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
            K_SW:   begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
            default: begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
        endcase
        return r;
    endfunction

    // ---------------- stimulus/compare engine ----------------
    // Entered just after a rising edge; applies one queued step per cycle.
    task automatic run_stream(input int k, input string name, input int limit);
        int n;
        step_t s;
        n = 0;
        while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
            s = exp_q.pop_front();
            instr_a[k] = s.instr;
            zero_a[k]  = s.zero;
            @(negedge clk);
            checks++;
            if (outs[k] !== s.c) begin
                failures++;
                $display("FAIL %s inst=%0d cycle=%0d got=%h exp=%h", name, k, n, outs[k], s.c);
            end
            n++;
            @(posedge clk); #1;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (outs[k] !== '0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got=%h exp=0", k, outs[k]);
            end
        end
    endtask

    task automatic test_add();
        do_reset();
        push_reset_cycle();
        model_instr(K_ADD, 0, 32'h002081B3, 1'b0);
        model_instr(K_ADD, 0, 32'h002081B3, 1'b0);
        run_stream(0, "add_w0", -1);
    endtask

    task automatic test_sub();
        do_reset();
        push_reset_cycle();
        model_instr(K_SUB, 2, 32'h402081B3, 1'b0);
        model_instr(K_SUB, 2, 32'h402081B3, 1'b0);
        run_stream(2, "sub_w2", -1);
    endtask

    task automatic test_load_store();
        do_reset();
        push_reset_cycle();
        model_instr(K_LW, 1, 32'h0000A183, 1'b0);
        model_instr(K_SW, 1, 32'h0030A023, 1'b0);
        model_instr(K_ADDI, 1, rand_instr(K_ADDI), 1'b0);
        run_stream(1, "lw_sw_w1", -1);
    endtask

    task automatic test_branch();
        do_reset();
        push_reset_cycle();
        model_instr(K_BEQ, 1, 32'h00208463, 1'b1);
        model_instr(K_BEQ, 1, 32'h00208463, 1'b0);
        model_instr(K_ADD, 1, 32'h002081B3, 1'b0);
        run_stream(1, "beq", -1);
    endtask

    task automatic test_trap();
        logic [31:0] bad [2];
        bad[0] = 32'hFFFFFFFF;
        bad[1] = 32'h022081B3;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            push_reset_cycle();
            model_instr(K_ILL, t, bad[t], 1'b0);
            run_stream(t, "trap", -1);
            rst = 1'b0;
            #1;
            checks++;
            if (outs[t] !== '0) begin
                failures++;
                $display("FAIL trap_clear inst=%0d got=%h exp=0", t, outs[t]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_reset_cycle();
        model_instr(K_SW, 3, 32'h0030A023, 1'b0);
        // reset(1) + fetch(4) + decode(1) + addr(1) + two of four store cycles
        run_stream(3, "async_pre", 9);
        #2;
        checks++;
        if (outs[3].mem_write !== 1'b1) begin
            failures++;
            $display("FAIL async_in_store got=%b exp=1", outs[3].mem_write);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (outs[3] !== '0) begin
            failures++;
            $display("FAIL async_abort got=%h exp=0", outs[3]);
        end
        @(posedge clk); #1 rst = 1'b1;
        push_reset_cycle();
        model_instr(K_ADD, 3, rand_instr(K_ADD), 1'b0);
        run_stream(3, "async_post", -1);
    endtask

    task automatic test_random();
        int k, kind;
        for (int it = 0; it < 10; it++) begin
            k = $urandom_range(0, 3);
            do_reset();
            push_reset_cycle();
            for (int j = 0; j < 6; j++) begin
                kind = $urandom_range(K_ADD, K_BEQ);
                model_instr(kind, k, rand_instr(kind), 1'($urandom));
            end
            run_stream(k, "random", -1);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            instr_a[k] = 32'h0;
            zero_a[k]  = 1'b0;
        end
        test_reset();
        test_add();
        test_sub();
        test_load_store();
        test_branch();
        test_trap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
